// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through
// read path selected by the FIFO_FWFT_EN macro.
//
//   FIFO_FWFT_EN undefined : buf_out is registered and updates on the edge
//                            that accepts a read (one-cycle read latency).
//   FIFO_FWFT_EN defined   : buf_out shows the head word combinationally
//                            whenever the FIFO is not empty, 0 when empty.
//
// Handshake: a write is taken on a rising edge when wr_en is high and the
// FIFO was not full at the start of that cycle; a read is taken when rd_en
// is high and the FIFO was not empty at the start of that cycle. Rejected
// requests only raise the matching sticky error flag. While rst is high
// every request is ignored.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] buf_in,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] buf_out,
    output logic             buf_empty,
    output logic             buf_full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    fifo_count,
    output logic             overflow,
    output logic             underflow
);

    // Thresholds expressed at the count width so every compare is width-matched.
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Status flags depend only on the registered occupancy.
    assign w_full   = (r_count == LP_DEPTH);
    assign w_empty  = (r_count == '0);

    // Acceptance is judged on the start-of-cycle flags; reset masks both.
    assign w_wr_acc = wr_en && !w_full  && !rst;
    assign w_rd_acc = rd_en && !w_empty && !rst;

    assign buf_full     = w_full;
    assign buf_empty    = w_empty;
    assign almost_full  = (r_count >= LP_AF);
    assign almost_empty = (r_count <= LP_AE);
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage array: written on an accepted write, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= buf_in;
        end
    end

    // Write pointer: advances on each accepted write and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer: advances on each accepted read and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags: a new error event outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through to the output whenever data is present.
    always_comb begin
        buf_out = '0;
        if (!w_empty) begin
            buf_out = r_mem[r_rd_ptr];
        end
    end
`else
    logic [WIDTH-1:0] r_buf_out;

    // Registered read data: loads the head word on an accepted read, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_out <= '0;
        end else if (w_rd_acc) begin
            r_buf_out <= r_mem[r_rd_ptr];
        end
    end

    assign buf_out = r_buf_out;
`endif

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO, the successor to the fixed 8-bit × 64 buffer. Width, depth and almost-full/almost-empty thresholds are configurable. It adds sticky overflow/underflow error flags and an optional first-word-fall-through read mode. It sits between a producer and a consumer in the same clock domain wherever the design needs elastic buffering.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `DEPTH`, 64, number of entries; power of 2, ≥4.
- `AF_LEVEL`, DEPTH-4, `almost_full` asserts when occupancy ≥ AF_LEVEL (1..DEPTH).
- `AE_LEVEL`, 4, `almost_empty` asserts when occupancy ≤ AE_LEVEL (0..DEPTH-1).
- Derived: `AW` = log2(DEPTH) is the pointer width; `CW` = AW+1 is the count width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_en`  in  1  write request.
- `buf_in`  in  WIDTH  write data.
- `rd_en`  in  1  read request.
- `err_clr`  in  1  clears `overflow` and `underflow`.
- `buf_out`  out  WIDTH  read data.
- `buf_empty`  out  1  occupancy == 0.
- `buf_full`  out  1  occupancy == DEPTH.
- `almost_empty`  out  1  occupancy ≤ AE_LEVEL.
- `almost_full`  out  1  occupancy ≥ AF_LEVEL.
- `fifo_count`  out  CW  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Write accepted (`wr_acc`) = `wr_en && !buf_full`. On acceptance, `mem[wr_ptr]` is loaded with `buf_in` and `wr_ptr` increments.
- Read accepted (`rd_acc`) = `rd_en && !buf_empty`. On acceptance, `rd_ptr` increments.
- Acceptance is always judged on the flags at the start of the cycle. When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.
- Both pointers are AW bits wide and wrap naturally from DEPTH-1 to 0. Decrementing a pointer is never permitted.
- Count update:
  - `wr_acc` only: `fifo_count` + 1.
  - `rd_acc` only: `fifo_count` − 1.
  - Both or neither: `fifo_count` unchanged.
  - `fifo_count` never exceeds DEPTH and never goes below 0.
- Status flags are decoded combinationally from the registered `fifo_count` only. They have no dependency on `wr_en` or `rd_en` in the same cycle.
- Error flags:
  - `overflow` sets on `wr_en && buf_full`.
  - `underflow` sets on `rd_en && buf_empty`.
  - Both clear only on `rst` or `err_clr`. If a set event and `err_clr` occur in the same cycle, the set wins.
  - A rejected access changes no other state.
- Reset values:
  - `fifo_count`=0, `wr_ptr`=0, `rd_ptr`=0, `buf_out`=0.
  - `buf_empty`=1, `buf_full`=0, `almost_empty`=1, `overflow`=0, `underflow`=0.
  - `almost_full`=0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. Any access in the reset cycle is ignored.

## Timing
- Standard mode: `buf_out` is registered and loads `mem[rd_ptr]` on the edge where `rd_acc` is true. Data is valid in the cycle after the accepted read. `buf_out` holds its value otherwise.
- Write-to-read latency: a word written at edge N changes `fifo_count`/`buf_empty` at edge N. It is readable with `rd_en` in the following cycle.
- All flags and `fifo_count` change only on a clock edge.

## Configuration
- `FIFO_FWFT_EN` defined (first-word-fall-through mode):
  - `buf_out` = `mem[rd_ptr]` whenever `!buf_empty`, and is 0 when empty.
  - The head word is visible before `rd_en`. `rd_acc` pops it, and the next word appears after that edge.
  - The first write into an empty FIFO is visible on `buf_out` in the cycle after the write edge.
- `FIFO_FWFT_EN` undefined: registered read as described under Timing.
- Flags, count and error behaviour are identical in both modes.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=4.
- Reset check: after `rst`, `buf_empty`=1, `almost_empty`=1, `fifo_count`=0, `buf_out`=0x00, and all other flags are 0.
- Fill: write 0x01..0x10 on 16 consecutive cycles.
  - `almost_full` rises after the 12th write.
  - `buf_full`=1 and `fifo_count`=16 after the 16th write.
  - A 17th write with 0xAA leaves `fifo_count`=16 and sets `overflow`=1.
- Drain: 16 consecutive reads return 0x01..0x10 in order, with one-cycle latency in standard mode and zero latency in FWFT mode.
  - `buf_empty`=1 after the last read.
  - An extra read sets `underflow` and leaves `buf_out`=0x10 in standard mode.
- Simultaneous access:
  - Empty FIFO, `wr_en`+`rd_en` with 0x55: the write is accepted, the read is rejected, `fifo_count`=1 and `underflow`=1.
  - At `fifo_count`=8, both asserted: count stays 8 and the data order is preserved.
- Wrap-around: 40 interleaved write/read pairs with incrementing data. Every word read out equals the word written, and `fifo_count` stays between 0 and 2.
- Mid-operation reset at `fifo_count`=9 gives the reset values next cycle. Asserting `err_clr` clears both sticky flags.
